// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the encoder and decoder tops.
//   - NR and the FSM state encodings
//   - GF(2^8) helpers (xtime, gmul, gf_inv) over the polynomial 0x11b
//   - sbox / inv_sbox, computed from the field inverse plus the affine map
//   - rcon table and sub_word helper for the key schedule
// No ports; import with "import aes_pkg::*;".
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] KEXP  = 3'd1;
    localparam logic [2:0] INIT  = 3'd2;
    localparam logic [2:0] ROUND = 3'd3;
    localparam logic [2:0] FINAL = 3'd4;

    typedef logic [31:0] word_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Field inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // Affine map: b ^ rotl(b,1..4) ^ 0x63
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine map: rotl(a,1) ^ rotl(a,3) ^ rotl(a,6) ^ 0x05, then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// Combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last)
// Ports:
//   st_in  [0:127]  state in, byte k = bits [8k:8k+7], column-major (byte = row + 4*col)
//   rk     [0:127]  round key, same byte order
//   last   1        final round: omit InvMixColumns
//   st_out [0:127]  next state
// -----------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [0:127] st_in,
    input  logic [0:127] rk,
    input  logic         last,
    output logic [0:127] st_out
);

    logic [0:127] added;
    logic [0:127] mixed;

    function automatic word_t inv_mix_col(input word_t col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        added = '0;
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                // InvShiftRows: row r rotates right by r, so out[r][c] = in[r][(c - r) mod 4]
                added[8*(r + 4*c) +: 8] = inv_sbox(st_in[8*(r + 4*((c - r + 4) % 4)) +: 8])
                                        ^ rk[8*(r + 4*c) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[32*c +: 32] = inv_mix_col(added[32*c +: 32]);
        end
        st_out = last ? added : mixed;
    end

endmodule

// File: rtl/aes_decoder.sv
// -----------------------------------------------------------------------------
// aes_decoder
// Iterative AES-128 inverse cipher, one round per clock. On start the key is
// expanded forward to round key 10 (10 cycles), then the inverse rounds run
// while round keys 9..0 are regenerated backwards. Result 21 edges after start.
// Ports:
//   clock        1        rising-edge clock
//   reset        1        synchronous, active-high
//   start        1        request, sampled only while idle
//   cipher_text  [0:127]  ciphertext, byte k = bits [8k:8k+7]
//   key          [0:127]  cipher key, same byte order
//   dec_data     [0:127]  recovered plaintext, held until the next completion
//   valid_flag   1        one-cycle pulse when dec_data updates
//   busy         1        high from start acceptance to the completion edge
// -----------------------------------------------------------------------------
module aes_decoder
    import aes_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] cipher_text,
    input  logic [0:127] key,
    output logic [0:127] dec_data,
    output logic         valid_flag,
    output logic         busy
);

    logic [2:0]   state;
    logic [3:0]   rnd;
    logic [0:127] st_reg;
    logic [0:127] rk_reg;
    logic [0:127] round_out;
    logic         last;

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // rk_i -> rk_i+1
    function automatic logic [0:127] fwd_key_step(input logic [0:127] rk, input logic [7:0] rc);
        word_t n0, n1, n2, n3;
        n0 = word_t'(rk[0:31]) ^ sub_word(rot_word(rk[96:127])) ^ {rc, 24'h0};
        n1 = word_t'(rk[32:63]) ^ n0;
        n2 = word_t'(rk[64:95]) ^ n1;
        n3 = word_t'(rk[96:127]) ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // rk_i -> rk_i-1; rc is Rcon[i]
    function automatic logic [0:127] inv_key_step(input logic [0:127] rk, input logic [7:0] rc);
        word_t p0, p1, p2, p3;
        p3 = word_t'(rk[96:127]) ^ word_t'(rk[64:95]);
        p2 = word_t'(rk[64:95]) ^ word_t'(rk[32:63]);
        p1 = word_t'(rk[32:63]) ^ word_t'(rk[0:31]);
        p0 = word_t'(rk[0:31]) ^ sub_word(rot_word(p3)) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    assign last = (state == FINAL);

    aes_inv_round u_inv_round (
        .st_in  (st_reg),
        .rk     (rk_reg),
        .last   (last),
        .st_out (round_out)
    );

    // NOTE: only control and outputs are reset; st_reg/rk_reg are always loaded
    // on acceptance before use, so resetting them would add muxes for nothing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            dec_data   <= '0;
            valid_flag <= 1'b0;
            busy       <= 1'b0;
            rnd        <= '0;
        end else begin
            valid_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        st_reg <= cipher_text;
                        rk_reg <= key;
                        rnd    <= 4'd1;
                        busy   <= 1'b1;
                        state  <= KEXP;
                    end
                end
                KEXP: begin
                    rk_reg <= fwd_key_step(rk_reg, rcon(rnd));
                    rnd    <= rnd + 4'd1;
                    if (rnd == NR) state <= INIT;
                end
                INIT: begin
                    st_reg <= st_reg ^ rk_reg;
                    rk_reg <= inv_key_step(rk_reg, rcon(NR));
                    rnd    <= NR - 4'd1;
                    state  <= ROUND;
                end
                ROUND: begin
                    st_reg <= round_out;
                    rk_reg <= inv_key_step(rk_reg, rcon(rnd));
                    rnd    <= rnd - 4'd1;
                    if (rnd == 4'd1) state <= FINAL;
                end
                FINAL: begin
                    dec_data   <= round_out;
                    valid_flag <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decoder.sv
// -----------------------------------------------------------------------------
// tb_aes_decoder
// Scoreboard bench for aes_decoder: stimulus pushes the expected plaintext into
// exp_q; a negedge monitor pops and compares whenever valid_flag is high.
// Timing, busy and reset behaviour are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_aes_decoder;
    import aes_pkg::*;

    localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    // AES-128 with all-zero key and all-zero plaintext
    localparam logic [127:0] V0_KEY = 128'h0;
    localparam logic [127:0] V0_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] V0_PT  = 128'h0;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [0:127] cipher_text;
    logic [0:127] key;
    logic [0:127] dec_data;
    logic         valid_flag;
    logic         busy;

    int n_checks = 0;
    int n_err    = 0;
    int rk_seen  = 0;
    bit rk_chk_en = 1'b0;
    logic [127:0] exp_q[$];
    logic [127:0] mon_exp;

    aes_decoder dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .cipher_text (cipher_text),
        .key         (key),
        .dec_data    (dec_data),
        .valid_flag  (valid_flag),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!reset && valid_flag) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", valid_flag, 1'b0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("dec_data", dec_data, mon_exp);
            end
        end
    end

    // Round key 10 must be present while the FSM sits in INIT
    always @(negedge clock) begin
        if (rk_chk_en && dut.state == INIT) begin
            rk_seen++;
            check("rk10_at_init", dut.rk_reg, V1_RK10);
        end
    end

    // One decryption; optionally fires ignored start pulses at E5 and E15.
    task automatic run_vector(input logic [127:0] ct, input logic [127:0] k,
                              input logic [127:0] exp, input bit pulses, input string tag);
        int n;
        cipher_text = ct;
        key         = k;
        start       = 1'b1;
        exp_q.push_back(exp);
        step();                                  // E0
        start = 1'b0;
        check({tag, "_busy_accept"}, busy, 1'b1);
        n = 0;
        while (!valid_flag && n < 40) begin
            if (pulses && (n == 4 || n == 14)) begin
                start       = 1'b1;
                cipher_text = V0_CT;
                key         = V2_KEY;
            end
            step();
            n++;
            start = 1'b0;
        end
        check({tag, "_latency"}, n, 21);
        check({tag, "_busy_done"}, busy, 1'b0);
        step();
        check({tag, "_valid_width"}, valid_flag, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        reset       = 1'b1;
        start       = 1'b0;
        cipher_text = '0;
        key         = '0;
        repeat (2) step();
        check("reset_valid", valid_flag, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_dec_data", dec_data, 128'h0);
        reset = 1'b0;
        step();

        // 1: FIPS-197 C.1, with round key 10 observed at INIT
        rk_chk_en = 1'b1;
        run_vector(V1_CT, V1_KEY, V1_PT, 1'b0, "c1");
        rk_chk_en = 1'b0;
        check("rk10_seen_once", rk_seen, 1);

        // 2: FIPS-197 Appendix B
        run_vector(V2_CT, V2_KEY, V2_PT, 1'b0, "b");

        // 3: start held high; the second request is sampled at the edge that
        //    closes the valid cycle, so its result lands 22 edges after the first.
        cipher_text = V1_CT;
        key         = V1_KEY;
        start       = 1'b1;
        exp_q.push_back(V1_PT);
        exp_q.push_back(V0_PT);
        step();                                  // E0
        cipher_text = V0_CT;
        key         = V0_KEY;
        n = 0;
        while (!valid_flag && n < 40) begin
            step();
            n++;
        end
        check("b2b_first_latency", n, 21);
        step();
        m = 1;
        while (!valid_flag && m < 40) begin
            step();
            m++;
        end
        start = 1'b0;
        check("b2b_second_gap", m, 22);
        step();
        check("b2b_valid_width", valid_flag, 1'b0);
        check("b2b_idle_busy", busy, 1'b0);

        // 4: start pulses while busy are ignored
        run_vector(V1_CT, V1_KEY, V1_PT, 1'b1, "ignore");

        // 5: reset at E12 aborts without a pulse; a fresh start then works
        cipher_text = V2_CT;
        key         = V2_KEY;
        start       = 1'b1;
        step();                                  // E0
        start = 1'b0;
        repeat (11) step();
        reset = 1'b1;
        step();                                  // E12
        check("abort_busy", busy, 1'b0);
        check("abort_valid", valid_flag, 1'b0);
        check("abort_dec_data", dec_data, 128'h0);
        reset = 1'b0;
        repeat (25) step();
        check("abort_no_pulse_busy", busy, 1'b0);
        run_vector(V2_CT, V2_KEY, V2_PT, 1'b0, "after_abort");

        // 6: idle hold with toggling inputs
        for (int i = 0; i < 50; i++) begin
            cipher_text = {$urandom, $urandom, $urandom, $urandom};
            key         = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("idle_valid", valid_flag, 1'b0);
            check("idle_dec_data", dec_data, V2_PT);
        end

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
